// File: rtl/spi_ram_pkg.sv
// ---------------------------------------------------------------------------
// spi_ram_pkg
// Shared definitions for the SPI-attached RAM block.
//   opcode_t : command opcodes carried in din[9:8]
//   state_t  : transmit state machine encoding
//   TX_BEATS : number of cycles tx_valid stays high per read
//   BEAT_W   : width of the beat counter that spans TX_BEATS
// ---------------------------------------------------------------------------
package spi_ram_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } opcode_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int TX_BEATS = 8;
    localparam int BEAT_W   = 3;

endpackage

// File: rtl/spi_ram_array.sv
// ---------------------------------------------------------------------------
// spi_ram_array
// Single-port byte storage with synchronous write and registered read.
// Accesses to addresses >= MEM_DEPTH are dropped on write and read back as
// 8'h00. Only the read-data register is reset; the storage itself is not.
// Assumes MEM_DEPTH <= 2**ADDR_SIZE.
//
// Parameters:
//   MEM_DEPTH : number of 8-bit words
//   ADDR_SIZE : width of the incoming address
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset of the read register
//   en    in   access strobe for this cycle
//   we    in   1 = write wdata, 0 = read into rdata
//   addr  in   word address
//   wdata in   write data
//   rdata out  registered read data, held until the next read
// ---------------------------------------------------------------------------
module spi_ram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [7:0]       mem [MEM_DEPTH];
    logic             in_range;
    logic [IDX_W-1:0] idx;

    // The upper address bits are used only for the range check; the array
    // itself is indexed by the low bits once the address is known valid.
    assign in_range = (32'(addr) < 32'(MEM_DEPTH));
    assign idx      = addr[IDX_W-1:0];

    // Storage write port: out-of-range writes are silently discarded so they
    // can never alias onto a real word through the truncated index.
    always_ff @(posedge clk) begin
        if (en && we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    // Registered read port: only a read updates rdata, so the value stays
    // put through writes and idle cycles until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else if (en && !we) begin
            rdata <= in_range ? mem[idx] : 8'h00;
        end
    end

endmodule

// File: rtl/spi_ram.sv
// ---------------------------------------------------------------------------
// spi_ram
// RAM behind an SPI slave. Each rx_valid episode carries one 10-bit command:
// din[9:8] opcode, din[7:0] payload. Opcodes set the write address, write a
// byte, set the read address, or read a byte out. A read presents dout and
// holds tx_valid high for TX_BEATS cycles so the slave can shift it out.
//
// Optional feature (compile-time macro RAM_AUTO_INC_EN): when defined, the
// write address advances after each write and the read address after each
// started read, wrapping from MEM_DEPTH-1 to 0.
//
// Parameters:
//   MEM_DEPTH : number of 8-bit words
//   ADDR_SIZE : address width, taken from din[ADDR_SIZE-1:0]
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   din      in   command word {opcode, payload}
//   rx_valid in   din valid; may stay high for several cycles
//   dout     out  read data for serialisation
//   tx_valid out  dout valid, high for TX_BEATS cycles per read
// ---------------------------------------------------------------------------
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    opcode_t               opcode;
    logic [ADDR_SIZE-1:0]  payload_addr;
    logic                  rx_valid_d;
    logic                  accept;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_SIZE-1:0]  wr_addr;
    logic [ADDR_SIZE-1:0]  rd_addr;
    logic [ADDR_SIZE-1:0]  mem_addr;
    state_t                state;
    logic [BEAT_W-1:0]     beat;

    assign opcode       = opcode_t'(din[9:8]);
    assign payload_addr = din[ADDR_SIZE-1:0];

    // A command is taken only on the rising edge of rx_valid, so a slave
    // that holds rx_valid for several cycles still issues one command.
    assign accept = rx_valid && !rx_valid_d;
    assign wr_en  = accept && (opcode == WR_DATA);
    assign rd_en  = accept && (opcode == RD_DATA) && (state == IDLE);

    // Writes and reads can never coincide since one command is accepted per
    // cycle, so a single shared address port is enough.
    assign mem_addr = wr_en ? wr_addr : rd_addr;
    assign tx_valid = (state == SEND);

    // Delayed copy of rx_valid used for the edge detect above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_d <= 1'b0;
        end else begin
            rx_valid_d <= rx_valid;
        end
    end

`ifdef RAM_AUTO_INC_EN
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [ADDR_SIZE-1:0] wr_addr_inc;
    logic [ADDR_SIZE-1:0] rd_addr_inc;

    // Next sequential addresses, wrapping at the top of the populated range.
    assign wr_addr_inc = (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_SIZE'(1);
    assign rd_addr_inc = (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_SIZE'(1);

    // Address registers: explicit loads from the address opcodes, plus a
    // post-increment after every write and every read that actually starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else if (accept) begin
            case (opcode)
                WR_ADDR: wr_addr <= payload_addr;
                WR_DATA: wr_addr <= wr_addr_inc;
                RD_ADDR: rd_addr <= payload_addr;
                RD_DATA: if (state == IDLE) rd_addr <= rd_addr_inc;
                default: ;
            endcase
        end
    end
`else
    // Address registers: only the address opcodes move them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else if (accept) begin
            case (opcode)
                WR_ADDR: wr_addr <= payload_addr;
                RD_ADDR: rd_addr <= payload_addr;
                default: ;
            endcase
        end
    end
`endif

    // Transmit FSM: a read in IDLE starts SEND with the beat counter at 0;
    // SEND lasts TX_BEATS cycles. Reads arriving during SEND are ignored
    // (rd_en already excludes them), other commands proceed untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en) begin
                        state <= SEND;
                        beat  <= '0;
                    end
                end
                SEND: begin
                    if (beat == BEAT_W'(TX_BEATS - 1)) begin
                        state <= IDLE;
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en || rd_en),
        .we    (wr_en),
        .addr  (mem_addr),
        .wdata (din[7:0]),
        .rdata (dout)
    );

endmodule

// File: tb/tb_spi_ram.sv
// ---------------------------------------------------------------------------
// tb_spi_ram
// Directed bench for spi_ram. Two instances: dut with default depth 256 and
// dut_s with MEM_DEPTH=128 for the out-of-range cases. Expected read data
// for dut is queued when a read is issued and popped when tx_valid rises.
// Honours RAM_AUTO_INC_EN for the address-sensitive steps.
// ---------------------------------------------------------------------------
module tb_spi_ram;

    localparam int TX_BEATS = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic [9:0] din_s = '0;
    logic       rx_valid_s = 1'b0;
    logic [7:0] dout_s;
    logic       tx_valid_s;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] sb [$];

    logic       prev_tx = 1'b0;
    int         run = 0;
    logic [7:0] held = '0;
    logic [7:0] exp_v;

    always #5 clk = ~clk;

    spi_ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

    spi_ram #(
        .MEM_DEPTH (128),
        .ADDR_SIZE (8)
    ) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din_s),
        .rx_valid (rx_valid_s),
        .dout     (dout_s),
        .tx_valid (tx_valid_s)
    );

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command, called on a falling edge. rx_valid stays high for
    // 'hold' cycles, then low for one cycle; returns on a falling edge.
    task automatic applyStimulus(input bit sel, input logic [1:0] op,
                                 input logic [7:0] pay, input int hold);
        if (sel) begin
            din_s = {op, pay};
            rx_valid_s = 1'b1;
        end else begin
            din = {op, pay};
            rx_valid = 1'b1;
        end
        repeat (hold) @(negedge clk);
        rx_valid   = 1'b0;
        rx_valid_s = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) for the selected instance to leave SEND.
    task automatic waitIdle(input bit sel);
        for (int i = 0; i < 20; i++) begin
            if (!(sel ? tx_valid_s : tx_valid)) break;
            @(negedge clk);
        end
        checkOutput(sel ? "send_end_s" : "send_end", 8'(sel ? tx_valid_s : tx_valid), 8'h00);
    endtask

    // Scoreboard monitor for dut: pops the expected byte on each tx_valid
    // rise, checks dout holds through SEND and the run is TX_BEATS long.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_tx = 1'b0;
            run = 0;
        end else begin
            if (tx_valid && !prev_tx) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_tx", 8'(tx_valid), 8'h00);
                end else begin
                    exp_v = sb.pop_front();
                    checkOutput("read_data", dout, exp_v);
                end
                run = 1;
                held = dout;
            end else if (tx_valid && prev_tx) begin
                run++;
                checkOutput("dout_hold", dout, held);
            end else if (!tx_valid && prev_tx) begin
                checkOutput("tx_beats", 8'(run), 8'(TX_BEATS));
                checkOutput("dout_after", dout, held);
            end
            prev_tx = tx_valid;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_dout", dout, 8'h00);
        checkOutput("rst_tx", 8'(tx_valid), 8'h00);
        checkOutput("rst_dout_s", dout_s, 8'h00);
        checkOutput("rst_tx_s", 8'(tx_valid_s), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back one byte
        applyStimulus(0, 2'b00, 8'h05, 1);
        applyStimulus(0, 2'b01, 8'hA7, 1);
        applyStimulus(0, 2'b10, 8'h05, 1);
        sb.push_back(8'hA7);
        applyStimulus(0, 2'b11, 8'h00, 1);
        checkOutput("tx_after_rd", 8'(tx_valid), 8'h01);
        waitIdle(0);

        // Extended write pulse: one write only
        applyStimulus(0, 2'b00, 8'h20, 1);
        applyStimulus(0, 2'b01, 8'h3C, 3);
        applyStimulus(0, 2'b01, 8'h4D, 1);
        applyStimulus(0, 2'b10, 8'h20, 1);
`ifdef RAM_AUTO_INC_EN
        sb.push_back(8'h3C);
        applyStimulus(0, 2'b11, 8'h00, 1);
        waitIdle(0);
        applyStimulus(0, 2'b10, 8'h21, 1);
        sb.push_back(8'h4D);
`else
        sb.push_back(8'h4D);
`endif
        applyStimulus(0, 2'b11, 8'h00, 1);
        waitIdle(0);

        // Read held high long past SEND: must not restart
        applyStimulus(0, 2'b10, 8'h05, 1);
        sb.push_back(8'hA7);
        applyStimulus(0, 2'b11, 8'h00, 14);
        waitIdle(0);

        // Commands during SEND
        applyStimulus(0, 2'b00, 8'h30, 1);
        applyStimulus(0, 2'b01, 8'h5A, 1);
        applyStimulus(0, 2'b10, 8'h30, 1);
        applyStimulus(0, 2'b00, 8'h31, 1);
        sb.push_back(8'h5A);
        applyStimulus(0, 2'b11, 8'h00, 1);
        applyStimulus(0, 2'b11, 8'h00, 1);
        applyStimulus(0, 2'b01, 8'h11, 1);
        applyStimulus(0, 2'b10, 8'h31, 1);
        checkOutput("send_busy", 8'(tx_valid), 8'h01);
        waitIdle(0);
        sb.push_back(8'h11);
        applyStimulus(0, 2'b11, 8'h00, 1);
        waitIdle(0);

        // Reset in the middle of SEND
        applyStimulus(0, 2'b00, 8'h00, 1);
        applyStimulus(0, 2'b01, 8'hE1, 1);
        applyStimulus(0, 2'b00, 8'h07, 1);
        applyStimulus(0, 2'b01, 8'h99, 1);
        applyStimulus(0, 2'b10, 8'h07, 1);
        sb.push_back(8'h99);
        applyStimulus(0, 2'b11, 8'h00, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_tx", 8'(tx_valid), 8'h00);
        checkOutput("midrst_dout", dout, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("no_restart", 8'(tx_valid), 8'h00);
        sb.push_back(8'hE1);
        applyStimulus(0, 2'b11, 8'h00, 1);
        waitIdle(0);

`ifdef RAM_AUTO_INC_EN
        // Address wrap at the top of memory
        applyStimulus(0, 2'b00, 8'hFF, 1);
        applyStimulus(0, 2'b01, 8'h01, 1);
        applyStimulus(0, 2'b01, 8'h02, 1);
        applyStimulus(0, 2'b10, 8'hFF, 1);
        sb.push_back(8'h01);
        applyStimulus(0, 2'b11, 8'h00, 1);
        waitIdle(0);
        sb.push_back(8'h02);
        applyStimulus(0, 2'b11, 8'h00, 1);
        waitIdle(0);
`endif

        // Out-of-range access on the 128-word instance
        applyStimulus(1, 2'b00, 8'h10, 1);
        applyStimulus(1, 2'b01, 8'h33, 1);
        applyStimulus(1, 2'b00, 8'h90, 1);
        applyStimulus(1, 2'b01, 8'h55, 1);
        applyStimulus(1, 2'b10, 8'h10, 1);
        applyStimulus(1, 2'b11, 8'h00, 1);
        checkOutput("alias_tx", 8'(tx_valid_s), 8'h01);
        checkOutput("alias_dout", dout_s, 8'h33);
        waitIdle(1);
        applyStimulus(1, 2'b10, 8'h90, 1);
        applyStimulus(1, 2'b11, 8'h00, 1);
        checkOutput("oor_tx", 8'(tx_valid_s), 8'h01);
        checkOutput("oor_dout", dout_s, 8'h00);
        waitIdle(1);
        checkOutput("oor_dout_idle", dout_s, 8'h00);

        checkOutput("sb_empty", 8'(sb.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
